// File: rtl/fc_requant_pkg.sv
// Shared types, widths and helpers for the requant writer stages.
// Optional rounding is selected with FC_REQUANT_ROUND_EN.
package fc_requant_pkg;

    localparam int SUM_W  = 33;
    localparam int PROD_W = 50;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } fc_wr_state_e;

    function automatic logic [7:0] sat_relu_u8(
        input logic signed [PROD_W-1:0] q
    );
        logic [7:0] r;
        if (q[PROD_W-1]) begin
            r = 8'd0;
        end else if (q > PROD_W'(255)) begin
            r = 8'hFF;
        end else begin
            r = q[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_requant_pipe.sv
// Three-stage bias / scale / shift+clamp datapath with valid and index tag.
// FC_REQUANT_ROUND_EN adds round-half-up before the final shift.
module fc_requant_pipe
    import fc_requant_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 16,
    parameter int IDX_W   = 6
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic [SCALE_W-1:0]       scale,
    input  logic [4:0]               shift,
    output logic                     pipe_busy,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_idx,
    output logic [7:0]               out_byte
);

    logic                     v1_q, v2_q, v3_q;
    logic [IDX_W-1:0]         idx1_q, idx2_q, idx3_q;
    logic signed [SUM_W-1:0]  sum_d, sum_q;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic signed [PROD_W-1:0] sum_ext, scale_ext;
    logic signed [PROD_W-1:0] rnd, q_wide;
    logic [7:0]               byte_d, byte_q;

    // Stage math: widen, add bias, multiply by unsigned scale.
    always_comb begin
        sum_d = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc}
              + {{(SUM_W-ACC_W){bias[ACC_W-1]}}, bias};
        sum_ext   = {{(PROD_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
        scale_ext = {{(PROD_W-SCALE_W){1'b0}}, scale};
        prod_d    = sum_ext * scale_ext;
    end

    // Final stage: optional rounding, arithmetic shift, ReLU clamp.
    always_comb begin
        rnd = '0;
`ifdef FC_REQUANT_ROUND_EN
        if (shift != 5'd0) begin
            rnd = PROD_W'(1) << (shift - 5'd1);
        end
`endif
        q_wide = (prod_q + rnd) >>> shift;
        byte_d = sat_relu_u8(q_wide);
    end

    // Pipeline registers; valids flush on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            idx1_q <= '0;
            idx2_q <= '0;
            idx3_q <= '0;
            sum_q  <= '0;
            prod_q <= '0;
            byte_q <= '0;
        end else begin
            v1_q   <= in_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            idx1_q <= in_idx;
            idx2_q <= idx1_q;
            idx3_q <= idx2_q;
            sum_q  <= sum_d;
            prod_q <= prod_d;
            byte_q <= byte_d;
        end
    end

    assign pipe_busy = v1_q | v2_q | v3_q;
    assign out_valid = v3_q;
    assign out_idx   = idx3_q;
    assign out_byte  = byte_q;

endmodule

// File: rtl/fc_requant_writer.sv
// Requant writer: FSM, channel counters, output buffer and read register.
// Build with FC_REQUANT_ROUND_EN for round-half-up requantisation.
module fc_requant_writer
    import fc_requant_pkg::*;
#(
    parameter int NUM_OUTPUTS = 64,
    parameter int ACC_W       = 32,
    parameter int SCALE_W     = 16,
    parameter int CNT_W       = $clog2(NUM_OUTPUTS+1)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [CNT_W-1:0]                 cfg_num_outputs,
    input  logic [SCALE_W-1:0]               cfg_scale,
    input  logic [4:0]                       cfg_shift,
    input  logic                             acc_valid,
    input  logic signed [ACC_W-1:0]          acc_data,
    input  logic signed [ACC_W-1:0]          bias,
    input  logic [$clog2(NUM_OUTPUTS)-1:0]   rd_addr,
    output logic [7:0]                       rd_data,
    output logic                             busy,
    output logic                             layer_done,
    output logic [CNT_W-1:0]                 out_count,
    output logic                             err
);

    localparam int AW = $clog2(NUM_OUTPUTS);

    fc_wr_state_e       state_d, state_q;
    logic [CNT_W-1:0]   num_d, num_q;
    logic [SCALE_W-1:0] scale_d, scale_q;
    logic [4:0]         shift_d, shift_q;
    logic [CNT_W-1:0]   acc_cnt_d, acc_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic               err_d, err_q;
    logic               done_d, done_q;
    logic               accept, clr_out;
    logic [7:0]         rd_q;

    logic               pipe_busy, wr_valid;
    logic [AW-1:0]      wr_idx;
    logic [7:0]         wr_byte;
    logic [7:0]         mem [NUM_OUTPUTS];

    fc_requant_pipe #(
        .ACC_W   (ACC_W),
        .SCALE_W (SCALE_W),
        .IDX_W   (AW)
    ) u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (accept),
        .in_idx    (acc_cnt_q[AW-1:0]),
        .acc       (acc_data),
        .bias      (bias),
        .scale     (scale_q),
        .shift     (shift_q),
        .pipe_busy (pipe_busy),
        .out_valid (wr_valid),
        .out_idx   (wr_idx),
        .out_byte  (wr_byte)
    );

    // Layer control: start/latch, channel accept, drain, completion.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        scale_d   = scale_q;
        shift_d   = shift_q;
        acc_cnt_d = acc_cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        clr_out   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d     = cfg_num_outputs;
                    scale_d   = cfg_scale;
                    shift_d   = cfg_shift;
                    acc_cnt_d = '0;
                    clr_out   = 1'b1;
                    if (cfg_num_outputs == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (acc_valid) begin
                    accept    = 1'b1;
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (acc_cnt_d == num_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr_out) begin
            err_d = 1'b0;
        end else if (acc_valid && !accept) begin
            err_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            scale_q   <= '0;
            shift_q   <= '0;
            acc_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            scale_q   <= scale_d;
            shift_q   <= shift_d;
            acc_cnt_q <= acc_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // Written-channel counter, bumped by each pipeline write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt_q <= '0;
        end else if (clr_out) begin
            out_cnt_q <= '0;
        end else if (wr_valid) begin
            out_cnt_q <= out_cnt_q + 1'b1;
        end
    end

    // Output buffer; contents deliberately survive reset and start.
    always_ff @(posedge clock) begin
        if (wr_valid) begin
            mem[wr_idx] <= wr_byte;
        end
    end

    // Registered read port; same-cycle write returns old data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data    = rd_q;
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
    assign layer_done = done_q;
    assign out_count  = out_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fc_requant_writer.sv
// Directed self-checking bench for fc_requant_writer.
// Expected bytes are hand-computed; rounding follows FC_REQUANT_ROUND_EN.
module tb_fc_requant_writer;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [6:0]         cfg_num_outputs = '0;
    logic [15:0]        cfg_scale = '0;
    logic [4:0]         cfg_shift = '0;
    logic               acc_valid = 1'b0;
    logic signed [31:0] acc_data = '0;
    logic signed [31:0] bias = '0;
    logic [5:0]         rd_addr = '0;
    logic [7:0]         rd_data;
    logic               busy;
    logic               layer_done;
    logic [6:0]         out_count;
    logic               err;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;

    fc_requant_writer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .cfg_num_outputs (cfg_num_outputs),
        .cfg_scale       (cfg_scale),
        .cfg_shift       (cfg_shift),
        .acc_valid       (acc_valid),
        .acc_data        (acc_data),
        .bias            (bias),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .layer_done      (layer_done),
        .out_count       (out_count),
        .err             (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (layer_done) done_cnt++;
    endtask

    task automatic do_start(input int n, input int sc, input int sh);
        start = 1'b1;
        cfg_num_outputs = 7'(n);
        cfg_scale = 16'(sc);
        cfg_shift = 5'(sh);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b);
        acc_valid = 1'b1;
        acc_data = a;
        bias = b;
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic rd(input int a, output int d);
        rd_addr = 6'(a);
        tick();
        d = int'(rd_data);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int s;
        s = done_cnt;
        for (int i = 0; i < budget && done_cnt == s; i++) begin
            tick();
        end
        chk(tag, done_cnt - s, 1);
    endtask

    initial begin
        int d;
        int s;
        int exp_rnd;

        reset_n = 1'b0;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(layer_done), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rd", int'(rd_data), 0);
        tick();
        reset_n = 1'b1;
        tick();

        send(5, 0);
        chk("idle_err", int'(err), 1);
        chk("idle_count", int'(out_count), 0);

        do_start(1, 1, 0);
        chk("start_clr_err", int'(err), 0);
        chk("start_busy", int'(busy), 1);
        send(136, 0);
        tick();
        tick();
        chk("lat_n2_count", int'(out_count), 0);
        tick();
        chk("lat_n3_count", int'(out_count), 1);
        chk("lat_n3_done", int'(layer_done), 0);
        chk("lat_n3_busy", int'(busy), 1);
        s = done_cnt;
        tick();
        chk("lat_n4_done", int'(layer_done), 1);
        chk("lat_n4_busy", int'(busy), 0);
        rd(0, d);
        chk("basic_byte", d, 136);
        chk("done_pulse_1cyc", int'(layer_done), 0);
        chk("basic_pulses", done_cnt - s, 1);

        do_start(3, 1, 0);
        for (int i = 0; i < 3; i++) begin
            acc_valid = 1'b1;
            acc_data = (i == 0) ? -50 : (i == 1) ? 1000 : 200;
            bias = -20;
            tick();
        end
        acc_valid = 1'b0;
        wait_done("sat_done", 10);
        chk("sat_count", int'(out_count), 3);
        rd(0, d);
        chk("sat_neg", d, 0);
        rd(1, d);
        chk("sat_hi", d, 255);
        rd(2, d);
        chk("sat_mid", d, 180);

`ifdef FC_REQUANT_ROUND_EN
        exp_rnd = 2;
`else
        exp_rnd = 1;
`endif
        do_start(1, 1, 1);
        send(3, 0);
        wait_done("rnd_done", 10);
        rd(0, d);
        chk("rnd_3_sh1", d, exp_rnd);
        do_start(1, 3, 2);
        send(100, 0);
        wait_done("scl_done", 10);
        rd(0, d);
        chk("scl_100x3_sh2", d, 75);

        do_start(64, 1, 0);
        s = done_cnt;
        for (int i = 0; i < 64; i++) begin
            acc_valid = 1'b1;
            acc_data = i;
            bias = 0;
            start = (i == 20);
            cfg_num_outputs = (i == 20) ? 7'd1 : 7'd64;
            tick();
        end
        start = 1'b0;
        chk("full_err_pre", int'(err), 0);
        acc_data = 999;
        tick();
        acc_valid = 1'b0;
        chk("drain_err", int'(err), 1);
        wait_done("full_done", 20);
        for (int i = 0; i < 4; i++) tick();
        chk("full_pulses", done_cnt - s, 1);
        chk("full_busy", int'(busy), 0);
        chk("full_count", int'(out_count), 64);
        chk("full_err_stick", int'(err), 1);
        for (int i = 0; i < 64; i++) begin
            rd(i, d);
            chk($sformatf("full_buf%0d", i), d, i);
        end

        s = done_cnt;
        do_start(0, 1, 0);
        chk("zero_done", int'(layer_done), 1);
        chk("zero_err_clr", int'(err), 0);
        chk("zero_busy", int'(busy), 0);
        chk("zero_count", int'(out_count), 0);
        rd(5, d);
        chk("zero_done_off", int'(layer_done), 0);
        chk("zero_buf_kept", d, 5);
        chk("zero_pulses", done_cnt - s, 1);

        do_start(64, 1, 0);
        for (int i = 0; i < 10; i++) begin
            acc_valid = 1'b1;
            acc_data = i + 100;
            bias = 0;
            tick();
        end
        acc_valid = 1'b0;
        chk("pre_rst_count", int'(out_count), 7);
        s = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(out_count), 0);
        chk("mid_rst_rd", int'(rd_data), 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_count", int'(out_count), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_pulses", done_cnt - s, 0);
        rd(0, d);
        chk("rst_buf0", d, 100);
        rd(6, d);
        chk("rst_buf6", d, 106);
        rd(7, d);
        chk("rst_buf7_old", d, 7);
        rd(9, d);
        chk("rst_buf9_old", d, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
